// File: rtl/debug_unit_ctrl.sv
// Byte-stream debug controller between a UART byte interface and the MIPS pipeline.
// Loads instruction memory, runs or single-steps the pipeline, and dumps PC/registers/data memory.
module debug_unit_ctrl #(
   parameter int LEN    = 32,
   parameter int N_REGS = 32,
   parameter int N_MEM  = 16,
   parameter int RD_LAT = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [7:0]     rx_data,
   input  logic           rx_done,
   output logic [7:0]     tx_data,
   output logic           tx_start,
   input  logic           tx_done,
   input  logic           halt_flag,
   input  logic [LEN-1:0] pc,
   input  logic [LEN-1:0] reg_data,
   input  logic [LEN-1:0] mem_data,
   output logic           mips_enable,
   output logic           debug_flag,
   output logic [LEN-1:0] addr_debug,
   output logic [LEN-1:0] addr_mem_inst,
   output logic [LEN-1:0] ins_to_mem,
   output logic           wea_ram_inst
);

   localparam logic [3:0] IDLE       = 4'd0;
   localparam logic [3:0] LOAD_CNT   = 4'd1;
   localparam logic [3:0] LOAD_BYTE  = 4'd2;
   localparam logic [3:0] LOAD_WRITE = 4'd3;
   localparam logic [3:0] RUN        = 4'd4;
   localparam logic [3:0] STEP       = 4'd5;
   localparam logic [3:0] DUMP_WAIT  = 4'd6;
   localparam logic [3:0] DUMP_SEND  = 4'd7;
   localparam logic [3:0] DUMP_ACK   = 4'd8;

   localparam logic [7:0] CMD_LOAD = 8'h01;
   localparam logic [7:0] CMD_RUN  = 8'h02;
   localparam logic [7:0] CMD_STEP = 8'h03;

   localparam int N_ITEMS = 1 + N_REGS + N_MEM;
   localparam int ITEM_W  = $clog2(N_ITEMS + 1);
   localparam int WAIT_W  = $clog2(RD_LAT + 1);
   localparam int BYTES   = LEN / 8;
   localparam int BYTE_W  = $clog2(BYTES);

   logic [3:0]        state_reg;
   logic [8:0]        word_total_reg;
   logic [8:0]        words_done_reg;
   logic [7:0]        load_idx_reg;
   logic [BYTE_W-1:0] byte_cnt_reg;
   logic [LEN-1:0]    ins_reg;
   logic              wea_reg;
   logic              mips_en_reg;
   logic              debug_reg;
   logic [LEN-1:0]    addr_debug_reg;
   logic [ITEM_W-1:0] item_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [LEN-1:0]    dump_word_reg;
   logic [7:0]        tx_data_reg;
   logic              tx_start_reg;
   logic [LEN-1:0]    item_word;
   logic              dump_go;

   // Item 0 is the PC (address unused), then registers, then data-memory words.
   function automatic logic [LEN-1:0] item_addr(input logic [ITEM_W-1:0] k);
      int ki;
      ki = int'(k);
      if (ki == 0)
         return '0;
      else if (ki <= N_REGS)
         return LEN'(ki - 1);
      else
         return LEN'(ki - 1 - N_REGS);
   endfunction

   always_comb begin
      item_word = mem_data;
      if (item_reg == '0)
         item_word = pc;
      else if (item_reg <= ITEM_W'(N_REGS))
         item_word = reg_data;
   end

   // A halted pipeline skips straight to the dump without ever enabling the clock.
   assign dump_go = (state_reg == RUN && halt_flag) ||
                    (state_reg == STEP) ||
                    (state_reg == IDLE && rx_done && rx_data == CMD_RUN && halt_flag);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         word_total_reg <= '0;
         words_done_reg <= '0;
         load_idx_reg   <= '0;
         byte_cnt_reg   <= '0;
         ins_reg        <= '0;
         wea_reg        <= 1'b0;
         mips_en_reg    <= 1'b0;
         debug_reg      <= 1'b0;
         addr_debug_reg <= '0;
         item_reg       <= '0;
         wait_cnt_reg   <= '0;
         dump_word_reg  <= '0;
         tx_data_reg    <= '0;
         tx_start_reg   <= 1'b0;
      end else begin
         tx_start_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rx_done) begin
                  case (rx_data)
                     CMD_LOAD: begin
                        state_reg <= LOAD_CNT;
                        debug_reg <= 1'b1;
                     end
                     CMD_RUN: begin
                        if (!halt_flag) begin
                           state_reg   <= RUN;
                           mips_en_reg <= 1'b1;
                        end
                     end
                     CMD_STEP: begin
                        state_reg   <= STEP;
                        mips_en_reg <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            LOAD_CNT: begin
               if (rx_done) begin
                  word_total_reg <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  words_done_reg <= '0;
                  load_idx_reg   <= '0;
                  byte_cnt_reg   <= '0;
                  state_reg      <= LOAD_BYTE;
               end
            end
            LOAD_BYTE: begin
               if (rx_done) begin
                  ins_reg      <= {ins_reg[LEN-9:0], rx_data};
                  byte_cnt_reg <= byte_cnt_reg + BYTE_W'(1);
                  if (byte_cnt_reg == BYTE_W'(BYTES - 1)) begin
                     wea_reg   <= 1'b1;
                     state_reg <= LOAD_WRITE;
                  end
               end
            end
            LOAD_WRITE: begin
               wea_reg        <= 1'b0;
               load_idx_reg   <= load_idx_reg + 8'd1;
               words_done_reg <= words_done_reg + 9'd1;
               if (words_done_reg + 9'd1 == word_total_reg) begin
                  state_reg <= IDLE;
                  debug_reg <= 1'b0;
               end else begin
                  state_reg <= LOAD_BYTE;
               end
            end
            RUN: ;
            STEP: ;
            DUMP_WAIT: begin
               // Read data settles RD_LAT cycles after addr_debug was registered.
               if (wait_cnt_reg == WAIT_W'(RD_LAT - 1)) begin
                  dump_word_reg <= item_word;
                  byte_cnt_reg  <= '0;
                  state_reg     <= DUMP_SEND;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            DUMP_SEND: begin
               tx_data_reg   <= dump_word_reg[LEN-1 -: 8];
               dump_word_reg <= dump_word_reg << 8;
               tx_start_reg  <= 1'b1;
               state_reg     <= DUMP_ACK;
            end
            DUMP_ACK: begin
               if (tx_done) begin
                  if (byte_cnt_reg == BYTE_W'(BYTES - 1)) begin
                     if (item_reg == ITEM_W'(N_ITEMS - 1)) begin
                        state_reg      <= IDLE;
                        debug_reg      <= 1'b0;
                        addr_debug_reg <= '0;
                        item_reg       <= '0;
                     end else begin
                        item_reg       <= item_reg + ITEM_W'(1);
                        addr_debug_reg <= item_addr(item_reg + ITEM_W'(1));
                        wait_cnt_reg   <= '0;
                        state_reg      <= DUMP_WAIT;
                     end
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + BYTE_W'(1);
                     state_reg    <= DUMP_SEND;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (dump_go) begin
            state_reg      <= DUMP_WAIT;
            mips_en_reg    <= 1'b0;
            debug_reg      <= 1'b1;
            item_reg       <= '0;
            addr_debug_reg <= '0;
            wait_cnt_reg   <= '0;
         end
      end
   end

   assign tx_data       = tx_data_reg;
   assign tx_start      = tx_start_reg;
   assign mips_enable   = mips_en_reg;
   assign debug_flag    = debug_reg;
   assign addr_debug    = addr_debug_reg;
   assign addr_mem_inst = {{(LEN-8){1'b0}}, load_idx_reg};
   assign ins_to_mem    = ins_reg;
   assign wea_ram_inst  = wea_reg;

endmodule
